// File: rtl/tick_scheduler.sv
// tick_scheduler: 1 ms prescaler driving NUM_CH periodic one-cycle clk-enable channels.
// Define TICK_SCHED_MS_COUNT_EN to add the free-running 16-bit ms_count output.
module tick_scheduler #(
  parameter int CLK_DIV  = 50000,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 10,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_ack,
  output logic                tick_ms,
`ifdef TICK_SCHED_MS_COUNT_EN
  output logic [15:0]         ms_count,
`endif
  output logic [NUM_CH-1:0]   ch_tick
);
  localparam int PS_W = $clog2(CLK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);
  logic [PS_W-1:0] ps;
  logic [PERIOD_W-1:0] period [NUM_CH];
  logic [PERIOD_W-1:0] cnt [NUM_CH];
  logic step;
  // A tick_ms already registered when run drops is discarded here.
  assign step = tick_ms & run;
  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= '0;
      tick_ms <= 1'b0;
      cfg_ack <= 1'b0;
      ch_tick <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      tick_ms <= run && ps == PS_MAX;
      if (run) ps <= ps == PS_MAX ? '0 : ps + 1'b1;
      cfg_ack <= cfg_we && 32'(cfg_ch) < NUM_CH;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_tick[i] <= 1'b0;
        // A write to this channel takes priority over any expiry in the same cycle.
        if (cfg_we && 32'(cfg_ch) == i) begin
          period[i] <= cfg_period;
          cnt[i] <= cfg_period;
        end else if (!ch_en[i]) begin
          cnt[i] <= period[i];
        end else if (period[i] == '0) begin
          cnt[i] <= '0;
        end else if (step) begin
          ch_tick[i] <= (cnt[i] <= PERIOD_W'(1));
          cnt[i] <= (cnt[i] <= PERIOD_W'(1)) ? period[i] : cnt[i] - 1'b1;
        end
      end
    end
  end
`ifdef TICK_SCHED_MS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) ms_count <= '0;
    else if (step) ms_count <= ms_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: config-write vector table, directed corner sequences and random stimulus
// checked every cycle against an elapsed-ms reference model.
module tb_tick_scheduler;
  localparam int CLK_DIV = 4, NUM_CH = 4, PERIOD_W = 10, CH_W = 3;
  logic clk = 1'b0;
  logic rst, run, cfg_we, cfg_ack, tick_ms;
  logic [NUM_CH-1:0] ch_en, ch_tick;
  logic [CH_W-1:0] cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
`ifdef TICK_SCHED_MS_COUNT_EN
  logic [15:0] ms_count;
`endif
  int checks = 0, fails = 0;
  always #5 clk = ~clk;

  tick_scheduler #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .run(run), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_ack(cfg_ack), .tick_ms(tick_ms),
`ifdef TICK_SCHED_MS_COUNT_EN
    .ms_count(ms_count),
`endif
    .ch_tick(ch_tick));

  // Reference model: counts running cycles and milliseconds elapsed per channel since its last restart.
  int run_cyc;
  int per_m[NUM_CH];
  int seen_m[NUM_CH];
  int e_ms;
  logic e_tick, e_ack;
  logic [NUM_CH-1:0] e_ch;
  always @(posedge clk) begin
    logic [NUM_CH-1:0] nch;
    nch = '0;
    if (rst) begin
      run_cyc = 0; e_tick = 0; e_ack = 0; e_ch = '0; e_ms = 0;
      for (int i = 0; i < NUM_CH; i++) begin per_m[i] = 0; seen_m[i] = 0; end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && int'(cfg_ch) == i) begin
          per_m[i] = int'(cfg_period);
          seen_m[i] = 0;
        end else if (!ch_en[i] || per_m[i] == 0) begin
          seen_m[i] = 0;
        end else if (e_tick && run) begin
          seen_m[i]++;
          if (seen_m[i] >= per_m[i]) begin nch[i] = 1'b1; seen_m[i] = 0; end
        end
      end
      if (e_tick && run) e_ms = (e_ms + 1) % 65536;
      e_ack = cfg_we && int'(cfg_ch) < NUM_CH;
      e_ch = nch;
      if (run) run_cyc++;
      e_tick = run && (run_cyc % CLK_DIV == 0);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("tick_ms", 32'(tick_ms), 32'(e_tick));
    chk("ch_tick", 32'(ch_tick), 32'(e_ch));
    chk("cfg_ack", 32'(cfg_ack), 32'(e_ack));
`ifdef TICK_SCHED_MS_COUNT_EN
    chk("ms_count", 32'(ms_count), 32'(e_ms[15:0]));
`endif
  endtask

  task automatic wait_ticks(input int k);
    int c = 0, b = 0;
    while (c < k && b < 400) begin
      cyc(); cfg_we = 1'b0; b++;
      if (tick_ms) c++;
    end
    if (c < k) chk("wait_ticks_timeout", 32'(c), 32'(k));
  endtask

  task automatic ticks_to_pulse(input int ch, output int n);
    int b = 0;
    bit hit = 0;
    n = 0;
    while (!hit && b < 400) begin
      cyc(); cfg_we = 1'b0; b++;
      if (ch_tick[ch]) hit = 1;
      else if (tick_ms) n++;
    end
    if (!hit) chk("pulse_timeout", 32'(0), 32'(1));
  endtask

  typedef struct { logic [CH_W-1:0] ch; logic [PERIOD_W-1:0] per; logic ack; } cfg_vec_t;
  cfg_vec_t tbl[6];

  initial begin
    int n;
    tbl = '{'{3'd0, 10'd3, 1'b1}, '{3'd1, 10'd1, 1'b1}, '{3'd2, 10'd2, 1'b1},
            '{3'd7, 10'd9, 1'b0}, '{3'd5, 10'd4, 1'b0}, '{3'd3, 10'd0, 1'b1}};
    rst = 1; run = 0; ch_en = '0; cfg_we = 0; cfg_ch = '0; cfg_period = '0;
    cyc(); cyc();
    chk("reset_outputs", 32'({tick_ms, ch_tick, cfg_ack}), 32'(0));
    rst = 0; run = 1;
    n = 0;
    do begin cyc(); n++; end while (!tick_ms && n < 20);
    chk("first_tick_edges", 32'(n), 32'(CLK_DIV));
    n = 0;
    do begin cyc(); n++; end while (!tick_ms && n < 20);
    chk("tick_spacing", 32'(n), 32'(CLK_DIV));
    repeat (12) begin cyc(); chk("no_ch_tick_unprogrammed", 32'(ch_tick), 32'(0)); end
    ch_en = '1;
    foreach (tbl[k]) begin
      cfg_we = 1; cfg_ch = tbl[k].ch; cfg_period = tbl[k].per;
      cyc();
      chk("tbl_ack", 32'(cfg_ack), 32'(tbl[k].ack));
    end
    cfg_we = 0;
    repeat (48) begin
      cyc();
      if (ch_tick[2]) chk("ch1_ch2_coincide", 32'(ch_tick[1]), 32'(1));
    end
    // Overwrite ch0 on the exact cycle it would expire.
    cfg_we = 1; cfg_ch = 0; cfg_period = 3;
    wait_ticks(3);
    cfg_we = 1; cfg_ch = 0; cfg_period = 5;
    ticks_to_pulse(0, n);
    chk("write_on_expiry_period", 32'(n), 32'(5));
    // Pause one ms into a 3 ms period.
    cfg_we = 1; cfg_ch = 0; cfg_period = 3;
    wait_ticks(1);
    cyc();
    run = 0;
    repeat (10) begin cyc(); chk("paused_quiet", 32'({tick_ms, ch_tick}), 32'(0)); end
    run = 1;
    ticks_to_pulse(0, n);
    chk("resume_remaining", 32'(n), 32'(2));
    // Disable ch0 for 2 ms; re-enable restarts a full period.
    cfg_we = 1; cfg_ch = 0; cfg_period = 3;
    wait_ticks(1);
    ch_en[0] = 0;
    wait_ticks(2);
    cyc();
    ch_en[0] = 1;
    ticks_to_pulse(0, n);
    chk("reenable_full_period", 32'(n), 32'(3));
    repeat (5) cyc();
    rst = 1;
    cyc();
    chk("midrun_reset", 32'({tick_ms, ch_tick, cfg_ack}), 32'(0));
    rst = 0;
    repeat (40) begin cyc(); chk("post_reset_periods_cleared", 32'(ch_tick), 32'(0)); end
    repeat (3000) begin
      run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) ch_en = NUM_CH'($urandom_range(0, 15));
      cfg_we = $urandom_range(0, 5) == 0;
      cfg_ch = CH_W'($urandom_range(0, 7));
      cfg_period = PERIOD_W'($urandom_range(0, 5));
      cyc();
    end
    cfg_we = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
